// File: rtl/uart_resp_pkg.sv
// Shared types and constants for the SDRAM-read-to-UART response packer.
// UART_RESP_HDR_EN prefixes every word with an ASCII 'D' header byte.
package uart_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } resp_state_t;

  localparam logic [7:0] RESP_HDR_BYTE = 8'h44;

`ifdef UART_RESP_HDR_EN
  localparam int BYTES_PER_WORD = 3;
`else
  localparam int BYTES_PER_WORD = 2;
`endif

endpackage

// File: rtl/resp_word_fifo.sv
// Synchronous 16-bit word FIFO with occupancy count and sticky drop-on-full flag.
module resp_word_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      wr_data,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [15:0]      rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty come from the registered count, so a pop in the same cycle
  // does not make room for a push that arrives while full.
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign push_ok  = wr_en && !full;
  assign pop_ok   = rd_en && !empty;
  assign rd_data  = mem[rd_ptr_reg];
  assign count    = count_reg;
  assign overflow = overflow_reg;

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (wr_en && full)
        overflow_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_resp_packer.sv
// Buffers 16-bit SDRAM read words and serialises them high byte first to uart_tx.
// Define UART_RESP_HDR_EN to prefix each word with header byte 0x44.
module uart_resp_packer
  import uart_resp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic [7:0]       tx_data,
  output logic             tx_send,
  input  logic             tx_busy,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic             idle
);

  localparam int               BIDX_W    = (BYTES_PER_WORD > 2) ? 2 : 1;
  localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(BYTES_PER_WORD - 1);

  resp_state_t       state_reg;
  logic [15:0]       hold_reg;
  logic [BIDX_W-1:0] bidx_reg;
  logic [15:0]       head_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic [BIDX_W-1:0] b);
`ifdef UART_RESP_HDR_EN
    case (b)
      2'd0:    pick_byte = RESP_HDR_BYTE;
      2'd1:    pick_byte = w[15:8];
      default: pick_byte = w[7:0];
    endcase
`else
    pick_byte = b[0] ? w[7:0] : w[15:8];
`endif
  endfunction

  assign pop        = (state_reg == ST_IDLE) && !fifo_empty && !tx_busy;
  assign word_ready = !fifo_full;
  assign idle       = fifo_empty && (state_reg == ST_IDLE);

  resp_word_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (word_in),
    .wr_en    (word_valid),
    .rd_en    (pop),
    .rd_data  (head_word),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  // tx_data/tx_send are loaded on entry to SEND, which only happens while
  // tx_busy is low, so the byte never moves under an active UART frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      hold_reg  <= '0;
      bidx_reg  <= '0;
      tx_send   <= 1'b0;
      tx_data   <= '0;
    end else begin
      tx_send <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            hold_reg  <= head_word;
            bidx_reg  <= '0;
            tx_data   <= pick_byte(head_word, '0);
            tx_send   <= 1'b1;
            state_reg <= ST_SEND;
          end
        end
        ST_SEND:  state_reg <= ST_GUARD;
        // uart_tx raises busy a cycle late; don't trust it yet.
        ST_GUARD: state_reg <= ST_WAIT;
        ST_WAIT: begin
          if (!tx_busy) begin
            if (bidx_reg == LAST_BIDX) begin
              state_reg <= ST_IDLE;
            end else begin
              bidx_reg  <= bidx_reg + BIDX_W'(1);
              tx_data   <= pick_byte(hold_reg, bidx_reg + BIDX_W'(1));
              tx_send   <= 1'b1;
              state_reg <= ST_SEND;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_resp_packer.sv
// Directed self-checking bench for uart_resp_packer with a simple uart_tx busy model.
// Honours UART_RESP_HDR_EN when building the expected byte stream.
module tb_uart_resp_packer;

  localparam int DEPTH    = 8;
  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int BUSY_CYC = 10;
`ifdef UART_RESP_HDR_EN
  localparam int BPW = 3;
`else
  localparam int BPW = 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [15:0]      word_in = '0;
  logic             word_valid = 1'b0;
  logic             word_ready;
  logic [7:0]       tx_data;
  logic             tx_send;
  logic             tx_busy = 1'b0;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic             idle;

  int         total = 0;
  int         bad = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         busy_cnt = 0;
  logic       force_busy = 1'b0;
  int         sends = 0;
  int         peak = 0;
  int         hold_viol = 0;
  logic [7:0] last_data = '0;
  int         s0;

  uart_resp_packer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .tx_data    (tx_data),
    .tx_send    (tx_send),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .idle       (idle)
  );

  always #10 clk = ~clk;

  // uart_tx stand-in: busy for BUSY_CYC cycles after each send pulse; also logs bytes.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (tx_busy && !tx_send && (tx_data !== last_data))
        hold_viol++;
      if (tx_send) begin
        rx_q.push_back(tx_data);
        sends++;
        $display("tx byte %02h at %0t", tx_data, $time);
        busy_cnt = BUSY_CYC;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      if (int'(fifo_count) > peak)
        peak = int'(fifo_count);
    end
    last_data = tx_data;
    tx_busy = force_busy || (busy_cnt != 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] first_byte(input logic [15:0] w);
`ifdef UART_RESP_HDR_EN
    first_byte = 8'h44;
`else
    first_byte = w[15:8];
`endif
  endfunction

  task automatic add_exp(input logic [15:0] w);
`ifdef UART_RESP_HDR_EN
    exp_q.push_back(8'h44);
`endif
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic push_word(input logic [15:0] w, input bit keep);
    word_in    = w;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    if (keep)
      add_exp(w);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++)
      step();
    chk("bytes_rx", rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && !idle; i++)
      step();
    chk("idle", {31'd0, idle}, 32'd1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_n"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk(tag, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    step();
    step();
    chk("rst_send",  {31'd0, tx_send},    32'd0);
    chk("rst_data",  {24'd0, tx_data},    32'd0);
    chk("rst_cnt",   {28'd0, fifo_count}, 32'd0);
    chk("rst_ovf",   {31'd0, overflow},   32'd0);
    chk("rst_ready", {31'd0, word_ready}, 32'd1);
    chk("rst_idle",  {31'd0, idle},       32'd1);
    rst = 1'b0;
    step();

    // single word: count=1 in cycle 1, first send in cycle 2
    push_word(16'hA55A, 1'b1);
    chk("lat_cnt",   {28'd0, fifo_count}, 32'd1);
    chk("lat_nosnd", {31'd0, tx_send},    32'd0);
    step();
    chk("lat_send",  {31'd0, tx_send},    32'd1);
    chk("lat_byte",  {24'd0, tx_data},    {24'd0, exp_q[0]});
    wait_bytes(BPW, 200);
    wait_idle(100);
    check_stream("single");

    // burst of three while uart is held busy
    force_busy = 1'b1;
    step();
    peak = 0;
    s0 = sends;
    push_word(16'h0102, 1'b1);
    push_word(16'h0304, 1'b1);
    push_word(16'h0506, 1'b1);
    chk("burst_cnt", {28'd0, fifo_count}, 32'd3);
    force_busy = 1'b0;
    wait_bytes(3 * BPW, 600);
    wait_idle(100);
    chk("burst_peak",  peak,       32'd3);
    chk("burst_sends", sends - s0, 3 * BPW);
    check_stream("burst");

    // overflow: nine pushes into an eight-deep FIFO
    force_busy = 1'b1;
    step();
    for (int i = 0; i < 8; i++)
      push_word(16'(32'h1000 + 32'h0111 * i), 1'b1);
    chk("ovf_ready", {31'd0, word_ready}, 32'd0);
    chk("ovf_cnt8",  {28'd0, fifo_count}, 32'd8);
    chk("ovf_flag0", {31'd0, overflow},   32'd0);
    push_word(16'hDEAD, 1'b0);
    chk("ovf_flag",  {31'd0, overflow},   32'd1);
    chk("ovf_cnt",   {28'd0, fifo_count}, 32'd8);
    force_busy = 1'b0;
    wait_bytes(8 * BPW, 2000);
    wait_idle(100);
    check_stream("ovf");

    // push coinciding with the IDLE->SEND pop
    force_busy = 1'b1;
    step();
    push_word(16'hC0DE, 1'b1);
    force_busy = 1'b0;
    step();
    push_word(16'h7E57, 1'b1);
    chk("pp_cnt",  {28'd0, fifo_count}, 32'd1);
    chk("pp_send", {31'd0, tx_send},    32'd1);
    wait_bytes(2 * BPW, 600);
    wait_idle(100);
    check_stream("pp");

    // reset in the cycle the first byte goes out
    push_word(16'h1234, 1'b0);
    push_word(16'h5678, 1'b0);
    exp_q.push_back(first_byte(16'h1234));
    chk("mid_send_pre", {31'd0, tx_send}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_send", {31'd0, tx_send},    32'd0);
    chk("mid_data", {24'd0, tx_data},    32'd0);
    chk("mid_cnt",  {28'd0, fifo_count}, 32'd0);
    chk("mid_ovf",  {31'd0, overflow},   32'd0);
    chk("mid_idle", {31'd0, idle},       32'd1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++)
      step();
    check_stream("rst");

    chk("hold_stable", hold_viol, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
